// File: rtl/wrr_sched_pkg.sv
// wrr_sched_pkg: shared types and defaults for the weighted round-robin port scheduler.
//   state_e    - scheduler FSM state (StIdle, StGrant)
//   Def*       - default parameter values
//   src_w()    - width of a requester index for a given requester count
//   src_idx_t  - requester index type for the default configuration
package wrr_sched_pkg;

    localparam int unsigned DefNumReq  = 8;
    localparam int unsigned DefDataW   = 64;
    localparam int unsigned DefWeightW = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

    // Never returns 0 so a one-requester build still gets a legal vector width.
    function automatic int unsigned src_w(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef logic [$clog2(DefNumReq)-1:0] src_idx_t;

endpackage

// File: rtl/wrr_port_scheduler_if.sv
// wrr_port_scheduler_if: requester-side and downstream-side signals of the scheduler.
//   req_valid/req_data/req_ready - per-requester valid/ready payload channels
//   weight                       - per-requester burst quota (0 disables the requester)
//   req_lock                     - per-requester quota lock (only with WRR_PORT_LOCK_EN)
//   out_valid/out_data/out_src/out_ready - shared downstream channel
//   busy                         - a grant is currently held
// Modports: master = the scheduler, slave = the surrounding requesters and downstream sink.
// Optional macro: WRR_PORT_LOCK_EN adds req_lock.
interface wrr_port_scheduler_if
    import wrr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned WEIGHT_W = DefWeightW
);
    localparam int unsigned SrcW = src_w(NUM_REQ);

    logic [NUM_REQ-1:0]  req_valid;
    logic [DATA_W-1:0]   req_data [NUM_REQ];
    logic [NUM_REQ-1:0]  req_ready;
    logic [WEIGHT_W-1:0] weight [NUM_REQ];
`ifdef WRR_PORT_LOCK_EN
    logic [NUM_REQ-1:0]  req_lock;
`endif
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [SrcW-1:0]     out_src;
    logic                out_ready;
    logic                busy;

    modport master (
        input  req_valid,
        input  req_data,
        input  weight,
`ifdef WRR_PORT_LOCK_EN
        input  req_lock,
`endif
        input  out_ready,
        output req_ready,
        output out_valid,
        output out_data,
        output out_src,
        output busy
    );

    modport slave (
        output req_valid,
        output req_data,
        output weight,
`ifdef WRR_PORT_LOCK_EN
        output req_lock,
`endif
        output out_ready,
        input  req_ready,
        input  out_valid,
        input  out_data,
        input  out_src,
        input  busy
    );

endinterface

// File: rtl/rr_pick.sv
// rr_pick: combinational circular first-set picker.
//   elig_i   - eligibility vector
//   start_i  - index where the circular search begins
//   onehot_o - one-hot of the picked requester (all zero when none)
//   idx_o    - index of the picked requester (0 when none)
//   any_o    - at least one requester is eligible
module rr_pick
    import wrr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = DefNumReq,
    parameter int unsigned IDX_W   = src_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] elig_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    localparam logic [IDX_W:0] NumReqW = (IDX_W + 1)'(NUM_REQ);

    // One spare bit so start + offset cannot overflow before the wrap.
    logic [IDX_W:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, start_i} + (IDX_W + 1)'(k);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!any_o && elig_i[cand[IDX_W-1:0]]) begin
                any_o                       = 1'b1;
                onehot_o[cand[IDX_W-1:0]]   = 1'b1;
                idx_o                       = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wrr_port_scheduler.sv
// wrr_port_scheduler: weighted, work-conserving round-robin sharing of one downstream
// request channel between NUM_REQ requesters. An owner keeps the channel for up to
// weight[owner] beats (sampled at grant time), or until it drops valid, then ownership
// rotates to the next eligible requester after it with no bubble.
//   clk   - clock
//   reset - asynchronous active-low reset
//   bus   - wrr_port_scheduler_if.master (requester channels, weights, downstream channel)
// Optional macro: WRR_PORT_LOCK_EN - a set req_lock[owner] at the quota-exhausting beat
// reloads the quota and keeps ownership.
module wrr_port_scheduler
    import wrr_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DefNumReq,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned WEIGHT_W = DefWeightW
) (
    input logic                  clk,
    input logic                  reset,
    wrr_port_scheduler_if.master bus
);

    localparam int unsigned     SrcW    = src_w(NUM_REQ);
    localparam logic [SrcW-1:0] LastIdx = SrcW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [SrcW-1:0]     owner_q, owner_d;
    logic [SrcW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;

    logic [NUM_REQ-1:0]  elig;
    logic [SrcW-1:0]     owner_inc;
    logic [SrcW-1:0]     pick_start;
    logic [NUM_REQ-1:0]  pick_onehot;
    logic [SrcW-1:0]     pick_idx;
    logic                pick_any;
    logic [WEIGHT_W-1:0] pick_weight;
    logic                granted;
    logic                owner_valid;
    logic                beat;
    logic                last_beat;
    logic                lock_hold;
    logic                release_grant;
    logic [DATA_W-1:0]   owner_data;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            elig[i] = bus.req_valid[i] & (bus.weight[i] != '0);
        end
    end

    assign owner_inc = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

    // While granted the only pick that matters is the re-pick at release, which always
    // searches from the slot after the owner; the owner therefore comes last and is only
    // re-granted when nobody else is eligible.
    assign granted    = (state_q == StGrant);
    assign pick_start = granted ? owner_inc : rr_ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (SrcW)
    ) u_rr_pick (
        .elig_i   (elig),
        .start_i  (pick_start),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        pick_weight = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_weight = pick_weight | bus.weight[i];
            end
        end
    end

    assign owner_valid = bus.req_valid[owner_q];
    assign beat        = granted & owner_valid & bus.out_ready;
    assign last_beat   = beat & (credit_q == WEIGHT_W'(1));

`ifdef WRR_PORT_LOCK_EN
    // A lock with a zeroed weight cannot reload a usable quota, so it releases instead.
    assign lock_hold = last_beat & bus.req_lock[owner_q] & (bus.weight[owner_q] != '0);
`else
    assign lock_hold = 1'b0;
`endif

    assign release_grant = granted & (~owner_valid | (last_beat & ~lock_hold));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        credit_d = credit_q;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d  = StGrant;
                    owner_d  = pick_idx;
                    credit_d = pick_weight;
                end
            end
            StGrant: begin
                if (release_grant) begin
                    rr_ptr_d = owner_inc;
                    if (pick_any) begin
                        owner_d  = pick_idx;
                        credit_d = pick_weight;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (lock_hold) begin
                    credit_d = bus.weight[owner_q];
                end else if (beat) begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end

    // Forward path is combinational from the registered owner; owner resets to 0 so
    // out_data follows req_data[0] out of reset.
    assign owner_data = bus.req_data[owner_q];

    always_comb begin
        bus.out_valid = 1'b0;
        bus.req_ready = '0;
        bus.out_src   = '0;
        bus.out_data  = owner_data;
        bus.busy      = granted;
        if (granted) begin
            bus.out_valid          = owner_valid;
            bus.out_src            = owner_q;
            bus.req_ready[owner_q] = bus.out_ready;
        end
    end

endmodule

// File: tb/tb_wrr_port_scheduler.sv
// tb_wrr_port_scheduler: directed scenarios plus randomized traffic, every cycle compared
// against a transaction-level reference model of the weighted round-robin rules.
module tb_wrr_port_scheduler;
    import wrr_sched_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int WW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wrr_port_scheduler_if #(.NUM_REQ(N), .DATA_W(DW), .WEIGHT_W(WW)) bus_if ();

    wrr_port_scheduler #(
        .NUM_REQ  (N),
        .DATA_W   (DW),
        .WEIGHT_W (WW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    logic [N-1:0]  valid;
    logic [N-1:0]  lock;
    logic [N-1:0]  accepted;
    logic [DW-1:0] data [N];
    logic [WW-1:0] weight [N];
    logic          ready;

    assign bus_if.req_valid = valid;
    assign bus_if.req_data  = data;
    assign bus_if.weight    = weight;
    assign bus_if.out_ready = ready;
`ifdef WRR_PORT_LOCK_EN
    assign bus_if.req_lock  = lock;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the channel and how many beats it has left.
    bit m_busy;
    int m_owner;
    int m_credit;
    int m_ptr;

    int beats[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_elig(input int i);
        return valid[i] && (weight[i] != 0);
    endfunction

    function automatic int pick_from(input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && is_elig(i)) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_credit = 0;
        m_ptr    = 0;
    endtask

    // Called at posedge+1 with inputs already set; checks at the negedge, advances the
    // model, then returns at the next posedge+1 with consumed payloads replaced.
    task automatic step();
        logic [N-1:0] exp_ready;
        bit rel, quota, others;
        int p, excl;
        @(negedge clk);
        exp_ready = '0;
        if (m_busy && ready) exp_ready[m_owner] = 1'b1;
        check("busy", 64'(bus_if.busy), 64'(m_busy));
        check("out_valid", 64'(bus_if.out_valid), 64'(m_busy && valid[m_owner]));
        check("req_ready", 64'(bus_if.req_ready), 64'(exp_ready));
        check("out_src", 64'(bus_if.out_src), m_busy ? 64'(m_owner) : 64'd0);
        if (m_busy && valid[m_owner]) check("out_data", bus_if.out_data, data[m_owner]);
        if (bus_if.out_valid && ready) beats.push_back(int'(bus_if.out_src));
        accepted = exp_ready & valid;

        if (!m_busy) begin
            p = pick_from(m_ptr, -1);
            if (p >= 0) begin
                m_busy   = 1'b1;
                m_owner  = p;
                m_credit = int'(weight[p]);
            end
        end else begin
            rel   = 1'b0;
            quota = 1'b0;
            if (!valid[m_owner]) begin
                rel = 1'b1;
            end else if (ready) begin
                if (m_credit == 1) begin
                    if (lock[m_owner] && weight[m_owner] != 0) begin
                        m_credit = int'(weight[m_owner]);
                    end else begin
                        rel   = 1'b1;
                        quota = 1'b1;
                    end
                end else begin
                    m_credit--;
                end
            end
            if (rel) begin
                m_ptr  = (m_owner + 1) % N;
                others = 1'b0;
                for (int i = 0; i < N; i++) if (i != m_owner && is_elig(i)) others = 1'b1;
                excl = (quota && others) ? m_owner : -1;
                p = pick_from(m_ptr, excl);
                if (p >= 0) begin
                    m_owner  = p;
                    m_credit = int'(weight[p]);
                end else begin
                    m_busy = 1'b0;
                end
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (accepted[i]) data[i] = {$urandom(), $urandom()};
    endtask

    // Entered at posedge+1; reset lands mid-cycle, so any beat in that cycle is dropped.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
        check("rst_out_src", 64'(bus_if.out_src), 64'd0);
        model_reset();
        accepted = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic quiet_reset();
        valid = '0;
        lock  = '0;
        ready = 1'b0;
        for (int i = 0; i < N; i++) weight[i] = '0;
        async_reset();
        beats.delete();
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N; i++) begin
            if (accepted[i]) valid[i] = ($urandom_range(3) != 0);
            else if (!valid[i]) valid[i] = ($urandom_range(2) == 0);
            if ($urandom_range(15) == 0) weight[i] = WW'($urandom_range(4));
`ifdef WRR_PORT_LOCK_EN
            lock[i] = ($urandom_range(3) == 0);
`endif
        end
        ready = ($urandom_range(3) != 0);
    endtask

    initial begin
        int exp_wrr [8];
        exp_wrr = '{0, 0, 0, 1, 0, 0, 0, 1};
        valid    = '0;
        lock     = '0;
        accepted = '0;
        ready    = 1'b0;
        for (int i = 0; i < N; i++) begin
            data[i]   = {$urandom(), $urandom()};
            weight[i] = '0;
        end
        #1;
        async_reset();

        // Reset during a live grant, then first grant from a clean start goes to 0.
        weight[0] = 8'd2;
        weight[3] = 8'd2;
        valid     = 4'b1001;
        ready     = 1'b1;
        step();
        step();
        async_reset();
        step();
        check("rst_first_busy", 64'(bus_if.busy), 64'd1);
        check("rst_first_src", 64'(bus_if.out_src), 64'd0);
        step();

        // Weights {3,1}: 0,0,0,1 repeating without bubbles.
        quiet_reset();
        weight[0] = 8'd3;
        weight[1] = 8'd1;
        valid     = 4'b0011;
        ready     = 1'b1;
        step();
        beats.delete();
        repeat (8) step();
        check("wrr_beats", 64'(beats.size()), 64'd8);
        for (int i = 0; i < 8 && i < beats.size(); i++) check("wrr_seq", 64'(beats[i]), 64'(exp_wrr[i]));

        // Sole requester re-grants itself back to back.
        quiet_reset();
        weight[2] = 8'd2;
        valid     = 4'b0100;
        ready     = 1'b1;
        step();
        check("single_no_beat_yet", 64'(beats.size()), 64'd0);
        repeat (6) step();
        check("single_beats", 64'(beats.size()), 64'd6);
        foreach (beats[i]) check("single_src", 64'(beats[i]), 64'd2);

        // Weight 0 disables the requester entirely.
        quiet_reset();
        valid = 4'b0010;
        ready = 1'b1;
        repeat (20) step();
        check("disabled_beats", 64'(beats.size()), 64'd0);
        check("disabled_ready", 64'(bus_if.req_ready[1]), 64'd0);

        // Backpressure holds the owner and its quota.
        quiet_reset();
        weight[0] = 8'd2;
        weight[1] = 8'd1;
        valid     = 4'b0011;
        ready     = 1'b0;
        step();
        repeat (5) step();
        check("bp_src_held", 64'(bus_if.out_src), 64'd0);
        check("bp_data_held", bus_if.out_data, data[0]);
        ready = 1'b1;
        beats.delete();
        repeat (3) step();
        check("bp_beats", 64'(beats.size()), 64'd3);
        if (beats.size() == 3) begin
            check("bp_seq0", 64'(beats[0]), 64'd0);
            check("bp_seq1", 64'(beats[1]), 64'd0);
            check("bp_seq2", 64'(beats[2]), 64'd1);
        end

`ifdef WRR_PORT_LOCK_EN
        // Lock keeps a weight-1 owner for extra beats.
        quiet_reset();
        weight[0] = 8'd1;
        weight[1] = 8'd1;
        valid     = 4'b0011;
        lock      = 4'b0001;
        ready     = 1'b1;
        step();
        beats.delete();
        repeat (3) step();
        lock = '0;
        repeat (2) step();
        check("lock_beats", 64'(beats.size()), 64'd5);
        if (beats.size() == 5) begin
            for (int i = 0; i < 4; i++) check("lock_seq", 64'(beats[i]), 64'd0);
            check("lock_rotate", 64'(beats[4]), 64'd1);
        end
`endif

        // Random traffic with occasional mid-run resets.
        quiet_reset();
        for (int i = 0; i < N; i++) weight[i] = WW'($urandom_range(4));
        for (int blk = 0; blk < 4; blk++) begin
            for (int c = 0; c < 800; c++) begin
                rand_inputs();
                step();
            end
            async_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
